timer_dev: RTL and testbench

- Programmable countdown timer on the CPU's device bus, one slot downstream of the CPU core behind the system bridge.
- Consumes the core's store/load traffic: device address, write data, byte enables, plus a bridge-decoded select.
- Returns read data on the device data input.
- Drives one interrupt line into the core's 6-bit interrupt request vector (the bridge maps it to bit 0).

---
 rtl/timer_dev_pkg.sv | 29 ++
 rtl/timer_dev.sv | 119 +++++++++++
 tb/tb_timer_dev.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// Shared register offsets, FSM states and CTRL field encodings for the countdown timer.
// Latency and backpressure: not applicable; this package holds declarations only.
package timer_dev_pkg;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Reserved 1x modes fold onto one-shot.
    function automatic logic [1:0] mode_eff(input logic [1:0] mode);
        return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Bus-mapped countdown timer with one-shot / auto-reload modes and a level interrupt.
// Latency: zero-wait combinational reads, writes commit on the clock edge; backpressure: none, always ready.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t            state_q, state_d;
    logic [3:0]        ctrl_q;
    logic [CNT_W-1:0]  preset_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_flag_q;

    logic              wr_ctrl, wr_preset;
    logic              en_eff, is_reload;
    logic              en_clr, flag_set;

    assign wr_ctrl   = sel && we && (addr == TIMER_CTRL) && be[0];
    assign wr_preset = sel && we && (addr == TIMER_PRESET);

    // A same-cycle CTRL write with EN=0 stops LOAD/CNT without touching COUNT.
    assign en_eff    = wr_ctrl ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];
    assign is_reload = (mode_eff(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]) == MODE_RELOAD);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        en_clr   = 1'b0;
        flag_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!en_eff) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (!en_eff) begin
                    state_d = S_IDLE;
                end else if (count_q <= CNT_W'(1)) begin
                    count_d = '0;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (!is_reload) begin
                    en_clr   = 1'b1;
                    flag_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            ctrl_q     <= '0;
            preset_q   <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;

            // Bus write wins over the one-shot EN clear.
            if (wr_ctrl) begin
                ctrl_q <= wdata[3:0];
            end else if (en_clr) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end

            for (int i = 0; i < 4; i++) begin
                if (wr_preset && be[i]) preset_q[8*i +: 8] <= wdata[8*i +: 8];
            end

            if (flag_set) begin
                irq_flag_q <= 1'b1;
            end else if (wr_ctrl && wdata[CTRL_EN]) begin
                irq_flag_q <= 1'b0;
            end
        end
    end

    // Auto-reload raises the flag only while sitting in INT.
    assign irq = ctrl_q[CTRL_IM] & (irq_flag_q | ((state_q == S_INT) && is_reload));

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                TIMER_CTRL:   rdata = {28'b0, ctrl_q};
                TIMER_PRESET: rdata = preset_q;
                TIMER_COUNT:  rdata = count_q;
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: register map, one-shot, auto-reload,
// stop/restart, byte lanes, same-cycle INT write and asynchronous reset.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    int          pulses;
    logic [31:0] d;

    timer_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] b);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = v;
        be    = b;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        we    = 1'b0;
        be    = 4'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        v    = rdata;
        sel  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        be    = 4'b0;
        wdata = 32'd0;

        // Reset values and read mux
        tick(2);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk("reset_read", d, 32'd0);
        end
        chk("reset_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        tick(1);
        addr = 2'd1;
        #1;
        chk("nosel_rdata", rdata, 32'd0);
        chk("nosel_irq", 32'(irq), 32'd0);

        // One-shot, PRESET=5: irq at write edge + 8
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        rd(2'd0, d);
        chk("os_ctrl_written", d, 32'h9);
        tick(2);
        for (int i = 5; i >= 1; i--) begin
            rd(2'd2, d);
            chk("os_count", d, 32'(i));
            tick(1);
        end
        rd(2'd2, d);
        chk("os_count_int", d, 32'd0);
        chk("os_irq_not_yet", 32'(irq), 32'd0);
        tick(1);
        chk("os_irq_rise", 32'(irq), 32'd1);
        rd(2'd0, d);
        chk("os_ctrl_en_cleared", d, 32'h8);

        // IM masks immediately but keeps the flag
        wr(2'd0, 32'h0, 4'hF);
        chk("im_mask", 32'(irq), 32'd0);
        wr(2'd0, 32'h8, 4'hF);
        chk("im_unmask", 32'(irq), 32'd1);
        tick(20);
        chk("os_irq_hold", 32'(irq), 32'd1);

        // Re-enable clears the flag and restarts
        wr(2'd0, 32'h9, 4'hF);
        chk("os_clear", 32'(irq), 32'd0);
        tick(2);
        rd(2'd2, d);
        chk("os_restart_count", d, 32'd5);
        wr(2'd0, 32'h0, 4'hF);
        rd(2'd2, d);
        chk("stop_freeze", d, 32'd5);

        // Auto-reload, PRESET=3: one-cycle pulse every 6 cycles
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            chk("ar_irq", 32'(irq), 32'((k >= 5) && ((k - 5) % 6 == 0)));
            pulses += int'(irq);
        end
        chk("ar_pulses", 32'(pulses), 32'd4);
        wr(2'd0, 32'h0, 4'hF);
        tick(2);

        // Stop mid-count at 100, then reload from a new PRESET
        wr(2'd1, 32'd200, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(102);
        rd(2'd2, d);
        chk("mid_count_100", d, 32'd100);
        wr(2'd0, 32'h8, 4'hF);
        tick(3);
        rd(2'd2, d);
        chk("mid_freeze_100", d, 32'd100);
        rd(2'd0, d);
        chk("mid_ctrl", d, 32'h8);
        wr(2'd1, 32'd7, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(2);
        rd(2'd2, d);
        chk("mid_reload_7", d, 32'd7);
        wr(2'd0, 32'h0, 4'hF);

        // Byte lanes, read-only COUNT, unused offset
        wr(2'd1, 32'h11223344, 4'hF);
        wr(2'd1, 32'hAABBCCDD, 4'b0001);
        rd(2'd1, d);
        chk("preset_lane0", d, 32'h112233DD);
        wr(2'd2, 32'h0000FFFF, 4'hF);
        rd(2'd2, d);
        chk("count_ro", d, 32'd7);
        wr(2'd3, 32'hFFFFFFFF, 4'hF);
        rd(2'd3, d);
        chk("addr3_zero", d, 32'd0);

        // CTRL write during one-shot INT: written EN kept, flag still set
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(12);
        rd(2'd2, d);
        chk("int_count", d, 32'd0);
        chk("int_irq_low", 32'(irq), 32'd0);
        wr(2'd0, 32'h9, 4'hF);
        chk("int_wr_irq", 32'(irq), 32'd1);
        rd(2'd0, d);
        chk("int_wr_en_kept", d, 32'h9);
        tick(3);
        rd(2'd2, d);
        chk("int_wr_recount", d, 32'd9);
        chk("int_wr_irq_held", 32'(irq), 32'd1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        rd(2'd2, d);
        chk("arst_count", d, 32'd0);
        rd(2'd0, d);
        chk("arst_ctrl", d, 32'd0);
        #1;
        reset = 1'b1;
        tick(20);
        chk("post_rst_irq", 32'(irq), 32'd0);
        rd(2'd2, d);
        chk("post_rst_count", d, 32'd0);
        rd(2'd1, d);
        chk("post_rst_preset", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
